smart_mac_pe_gen: RTL and testbench
===================================

SMART_MAC_PE_GEN -- requirements
Module: smart_mac_pe_gen

Interface
REQ-001 Parameter WORD_SIZE, default 16: operand and pass-through data width.
REQ-002 Parameter ACC_WIDTH, default 40: accumulator width; SHALL be at least 2*WORD_SIZE.
REQ-003 Parameter CNT_WIDTH, default 8: width of the MAC-count register.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 mode_in  in  1  0 = output-stationary (OS), 1 = weight-stationary (WS); sampled at start.
REQ-007 start_in  in  1  one-cycle pulse that begins a job; ignored unless state is IDLE.
REQ-008 count_in  in  CNT_WIDTH  number of valid MAC operations in the job; sampled at start.
REQ-009 select_left_in_smart, select_top_in_smart  in  1 each  1 = take operand from the horizontal/vertical smart bus instead of left_in/top_in.
REQ-010 select_right_out_smart, select_bottom_out_smart  in  1 each  1 = drive right_out/bottom_out onto the horizontal/vertical bus output instead of passing the bus input through.
REQ-011 left_in, top_in  in  WORD_SIZE  signed operands; left_valid_in, top_valid_in  in  1  qualifiers.
REQ-012 horizontal_smart_bus_in, vertical_smart_bus_in  in  WORD_SIZE; horizontal_smart_bus_out, vertical_smart_bus_out  out  WORD_SIZE.
REQ-013 right_out, bottom_out  out  WORD_SIZE; right_valid_out, bottom_valid_out  out  1.
REQ-014 result_out  out  ACC_WIDTH; result_valid_out  out  1; busy_out  out  1; done_out  out  1.

Function
REQ-015 Operand muxes and bus-output muxes SHALL be combinational; bus valids SHALL follow the same selects as the data.
REQ-016 FSM states: IDLE, LOAD (WS only), COMPUTE, DRAIN; busy_out SHALL be 1 in every state except IDLE.
REQ-017 IDLE + start_in: latch mode_in and count_in, and clear the accumulator. With count_in = 0, go to DRAIN. Otherwise go to LOAD if WS, or to COMPUTE if OS.
REQ-018 LOAD: on the first cycle with top operand valid, capture it into the weight register, then go to COMPUTE; nothing is forwarded.
REQ-019 OS COMPUTE: a MAC fires only when both operand valids are 1. On fire: acc <= sat(acc + a*b), signed.
REQ-020 OS COMPUTE forwarding: on fire, right_out <= a and bottom_out <= b, each registered with 1-cycle latency and valid = 1; otherwise both valids SHALL be 0.
REQ-021 WS COMPUTE: a MAC fires when the left valid is 1; the top operand is the incoming partial sum (treated as 0 if top valid is 0).
REQ-022 WS COMPUTE outputs: right_out <= a; bottom_out <= satW(psum + weight*a); both registered with 1-cycle latency.
REQ-023 sat() SHALL clamp to the signed ACC_WIDTH range; satW() SHALL clamp to the signed WORD_SIZE range. Overflow SHALL never wrap.
REQ-024 A down-counter decrements on each fire; on the fire that reaches 0, go to DRAIN. Operands arriving after that fire are ignored and not forwarded.
REQ-025 DRAIN lasts one cycle: result_valid_out = 1 and done_out = 1; result_out = acc in OS and 0 in WS; next state is IDLE.
REQ-026 result_out SHALL hold its value until the next start; result_valid_out and done_out are single-cycle pulses.
REQ-027 start_in while not in IDLE SHALL be ignored, with no effect on the running job.

Reset
REQ-028 Asserting rst (low) at any time, including mid-job, SHALL immediately force: state IDLE; acc, weight and counter to 0; all data outputs to 0; all valid, busy and done outputs to 0.
REQ-029 After rst is released, the first accepted start_in SHALL behave as in REQ-017.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the mode constants (MODE_OS = 0, MODE_WS = 1) and the saturation-bound function.
REQ-031 The multiply-add-saturate datapath SHALL be one sub-module, smart_mac_sat_mult (combinational, parametrised by input and output widths), instantiated for both the OS and WS paths.

Verification
REQ-032 OS, count 3, operands (2,3), (-4,5), (7,1) with both valids held high -> right/bottom echo the operands 1 cycle later; result_out = -7 with a 1-cycle result_valid_out/done_out.
REQ-033 OS, count 2, left valid toggling while top valid stays high -> only paired cycles accumulate; operands (3,3), (1,-2) -> result 7.
REQ-034 WS, count 2: weight 5 loaded; left 2 with psum 10 -> bottom_out 20; left -3 with psum 0 -> bottom_out -15; then done pulse.
REQ-035 WORD_SIZE 16, WS, weight 32767, left 2, psum 1 -> bottom_out 32767 (saturated); OS with ACC_WIDTH 32 accumulating 32767*32767 three times -> result_out 2147483647.
REQ-036 Bus selects all 1, bus inputs 0x00AA / 0x0055 -> operands taken from the buses, bus outputs carry right_out/bottom_out. Bus selects all 0 -> bus outputs equal bus inputs in the same cycle.
REQ-037 rst pulsed low mid-COMPUTE (count 4, after 2 fires) -> all outputs 0 immediately. A new start with count 1 and operands (6,7) -> result_out 42.

Source files
------------

// File: rtl/smart_mac_pe_gen_pkg.sv
// rtl/smart_mac_pe_gen_pkg.sv - shared FSM encoding, mode constants and saturation bounds
// No ports: provides state_e, MODE_OS/MODE_WS, SAT_W and sat_bound().
package smart_mac_pe_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam logic MODE_OS = 1'b0;
    localparam logic MODE_WS = 1'b1;

    // Working width for clamp comparisons; wide enough for any sensible
    // accumulator plus the product guard bits.
    localparam int SAT_W = 128;

    // Largest (upper = 1) or smallest (upper = 0) two's-complement value
    // representable in 'width' bits, sign-extended to SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_bound(input int width, input logic upper);
        logic signed [SAT_W-1:0] unit;
        unit    = '0;
        unit[0] = 1'b1;
        if (upper) begin
            return (unit <<< (width - 1)) - unit;
        end
        return -(unit <<< (width - 1));
    endfunction

endpackage

// File: rtl/smart_mac_sat_mult.sv
// rtl/smart_mac_sat_mult.sv - combinational signed y = sat(addend + a*b)
// Ports:
//   a, b    in  IN_W   signed multiplicands
//   addend  in  ADD_W  signed value added to the product
//   y       out OUT_W  sum clamped to the signed OUT_W range
module smart_mac_sat_mult
    import smart_mac_pe_gen_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ADD_W = 40,
    parameter int OUT_W = 40
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic signed [ADD_W-1:0] addend,
    output logic signed [OUT_W-1:0] y
);

    // One guard bit above the wider of product and addend so the exact
    // sum is always representable before clamping.
    localparam int FULL_W = ((ADD_W > 2 * IN_W) ? ADD_W : 2 * IN_W) + 1;

    logic signed [FULL_W-1:0] sum;
    logic signed [SAT_W-1:0]  sum_ext;
    logic signed [SAT_W-1:0]  hi;
    logic signed [SAT_W-1:0]  lo;

    assign sum     = FULL_W'(addend) + FULL_W'(a) * FULL_W'(b);
    assign sum_ext = SAT_W'(sum);
    assign hi      = sat_bound(OUT_W, 1'b1);
    assign lo      = sat_bound(OUT_W, 1'b0);

    always_comb begin
        y = OUT_W'(sum_ext);
        if (sum_ext > hi) begin
            y = OUT_W'(hi);
        end else if (sum_ext < lo) begin
            y = OUT_W'(lo);
        end
    end

endmodule

// File: rtl/smart_mac_pe_gen.sv
// rtl/smart_mac_pe_gen.sv - systolic MAC processing element with smart-bus bypass
// Ports:
//   clk, rst (async, active-low)
//   mode_in, start_in, count_in                      job control, sampled on start
//   select_{left_in,top_in}_smart                    operand source: bus vs neighbour
//   select_{right_out,bottom_out}_smart              bus output: local result vs pass-through
//   left_in/top_in (+valid), *_smart_bus_in          operand and bus inputs
//   right_out/bottom_out (+valid), *_smart_bus_out   forwarded data and bus outputs
//   result_out, result_valid_out, busy_out, done_out job status
module smart_mac_pe_gen
    import smart_mac_pe_gen_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_in,
    input  logic                 start_in,
    input  logic [CNT_WIDTH-1:0] count_in,
    input  logic                 select_left_in_smart,
    input  logic                 select_top_in_smart,
    input  logic                 select_right_out_smart,
    input  logic                 select_bottom_out_smart,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic                 left_valid_in,
    input  logic [WORD_SIZE-1:0] top_in,
    input  logic                 top_valid_in,
    input  logic [WORD_SIZE-1:0] horizontal_smart_bus_in,
    input  logic [WORD_SIZE-1:0] vertical_smart_bus_in,
    output logic [WORD_SIZE-1:0] horizontal_smart_bus_out,
    output logic [WORD_SIZE-1:0] vertical_smart_bus_out,
    output logic [WORD_SIZE-1:0] right_out,
    output logic                 right_valid_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    output logic                 bottom_valid_out,
    output logic [ACC_WIDTH-1:0] result_out,
    output logic                 result_valid_out,
    output logic                 busy_out,
    output logic                 done_out
);

    state_e                       state;
    state_e                       state_next;
    logic                         mode_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_mac;
    logic signed [ACC_WIDTH-1:0]  result_q;
    logic signed [WORD_SIZE-1:0]  weight_q;
    logic signed [WORD_SIZE-1:0]  op_a;
    logic signed [WORD_SIZE-1:0]  op_b;
    logic signed [WORD_SIZE-1:0]  psum;
    logic signed [WORD_SIZE-1:0]  ws_y;
    logic                         fire;
    logic                         last_fire;

    // The operand valids qualify whichever source the selects route in.
    assign op_a = select_left_in_smart ? horizontal_smart_bus_in : left_in;
    assign op_b = select_top_in_smart  ? vertical_smart_bus_in   : top_in;

    assign horizontal_smart_bus_out = select_right_out_smart  ? right_out  : horizontal_smart_bus_in;
    assign vertical_smart_bus_out   = select_bottom_out_smart ? bottom_out : vertical_smart_bus_in;

    // In WS the top lane carries a partial sum; an idle top lane adds nothing.
    assign psum = top_valid_in ? op_b : '0;

    assign fire = (state == ST_COMPUTE) && left_valid_in &&
                  ((mode_q == MODE_WS) || top_valid_in);
    assign last_fire = fire && (cnt_q == CNT_WIDTH'(1));

    smart_mac_sat_mult #(
        .IN_W  (WORD_SIZE),
        .ADD_W (ACC_WIDTH),
        .OUT_W (ACC_WIDTH)
    ) u_os_mac (
        .a      (op_a),
        .b      (op_b),
        .addend (acc_q),
        .y      (acc_mac)
    );

    smart_mac_sat_mult #(
        .IN_W  (WORD_SIZE),
        .ADD_W (WORD_SIZE),
        .OUT_W (WORD_SIZE)
    ) u_ws_mac (
        .a      (weight_q),
        .b      (op_a),
        .addend (psum),
        .y      (ws_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the status outputs that are pure functions of state.
    // result_out shows the live value during DRAIN and the held copy after.
    always_comb begin
        state_next       = state;
        busy_out         = (state != ST_IDLE);
        result_valid_out = 1'b0;
        done_out         = 1'b0;
        result_out       = result_q;
        case (state)
            ST_IDLE: begin
                if (start_in) begin
                    if (count_in == '0) begin
                        state_next = ST_DRAIN;
                    end else if (mode_in == MODE_WS) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_COMPUTE;
                    end
                end
            end
            ST_LOAD: begin
                if (top_valid_in) begin
                    state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (last_fire) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next       = ST_IDLE;
                result_valid_out = 1'b1;
                done_out         = 1'b1;
                result_out       = (mode_q == MODE_OS) ? acc_q : '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q           <= MODE_OS;
            cnt_q            <= '0;
            acc_q            <= '0;
            result_q         <= '0;
            weight_q         <= '0;
            right_out        <= '0;
            bottom_out       <= '0;
            right_valid_out  <= 1'b0;
            bottom_valid_out <= 1'b0;
        end else begin
            right_valid_out  <= 1'b0;
            bottom_valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        mode_q <= mode_in;
                        cnt_q  <= count_in;
                        acc_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (top_valid_in) begin
                        weight_q <= op_b;
                    end
                end
                ST_COMPUTE: begin
                    if (fire) begin
                        cnt_q            <= cnt_q - CNT_WIDTH'(1);
                        right_out        <= op_a;
                        right_valid_out  <= 1'b1;
                        bottom_valid_out <= 1'b1;
                        if (mode_q == MODE_OS) begin
                            acc_q      <= acc_mac;
                            bottom_out <= op_b;
                        end else begin
                            bottom_out <= ws_y;
                        end
                    end
                end
                ST_DRAIN: begin
                    result_q <= (mode_q == MODE_OS) ? acc_q : '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smart_mac_pe_gen.sv
// tb/tb_smart_mac_pe_gen.sv - scoreboard bench for smart_mac_pe_gen
module tb_smart_mac_pe_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode_in = 1'b0;
    logic        start_in = 1'b0;
    logic        start32 = 1'b0;
    logic [7:0]  count_in = '0;
    logic        sel_l = 1'b0, sel_t = 1'b0, sel_r = 1'b0, sel_b = 1'b0;
    logic [15:0] left_in = '0, top_in = '0;
    logic        lv = 1'b0, tv = 1'b0;
    logic [15:0] hbus_in = '0, vbus_in = '0;

    logic [15:0] hbus_out, vbus_out, right_out, bottom_out;
    logic        right_valid_out, bottom_valid_out, result_valid_out, busy_out, done_out;
    logic [39:0] result_out;

    logic [15:0] hbus32, vbus32, right32, bottom32;
    logic        rv32, bv32, resv32, busy32, done32;
    logic [31:0] result32;

    longint exp_right[$], exp_bottom[$], exp_result[$], exp_result32[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    smart_mac_pe_gen dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .start_in(start_in), .count_in(count_in),
        .select_left_in_smart(sel_l), .select_top_in_smart(sel_t),
        .select_right_out_smart(sel_r), .select_bottom_out_smart(sel_b),
        .left_in(left_in), .left_valid_in(lv), .top_in(top_in), .top_valid_in(tv),
        .horizontal_smart_bus_in(hbus_in), .vertical_smart_bus_in(vbus_in),
        .horizontal_smart_bus_out(hbus_out), .vertical_smart_bus_out(vbus_out),
        .right_out(right_out), .right_valid_out(right_valid_out),
        .bottom_out(bottom_out), .bottom_valid_out(bottom_valid_out),
        .result_out(result_out), .result_valid_out(result_valid_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    smart_mac_pe_gen #(.WORD_SIZE(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut32 (
        .clk(clk), .rst(rst), .mode_in(mode_in), .start_in(start32), .count_in(count_in),
        .select_left_in_smart(sel_l), .select_top_in_smart(sel_t),
        .select_right_out_smart(sel_r), .select_bottom_out_smart(sel_b),
        .left_in(left_in), .left_valid_in(lv), .top_in(top_in), .top_valid_in(tv),
        .horizontal_smart_bus_in(hbus_in), .vertical_smart_bus_in(vbus_in),
        .horizontal_smart_bus_out(hbus32), .vertical_smart_bus_out(vbus32),
        .right_out(right32), .right_valid_out(rv32),
        .bottom_out(bottom32), .bottom_valid_out(bv32),
        .result_out(result32), .result_valid_out(resv32),
        .busy_out(busy32), .done_out(done32)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic unexpected(input string name, input longint act);
        total_cnt++;
        $display("FAIL %s: got valid output %0d, expected no output", name, act);
    endtask

    // Monitor: every valid output pops the oldest expectation of its lane.
    always @(negedge clk) begin
        if (right_valid_out) begin
            if (exp_right.size() == 0) unexpected("right_out", $signed(right_out));
            else check("right_out", $signed(right_out), exp_right.pop_front());
        end
        if (bottom_valid_out) begin
            if (exp_bottom.size() == 0) unexpected("bottom_out", $signed(bottom_out));
            else check("bottom_out", $signed(bottom_out), exp_bottom.pop_front());
        end
        if (result_valid_out) begin
            check("done_out", longint'(done_out), 1);
            if (exp_result.size() == 0) unexpected("result_out", $signed(result_out));
            else check("result_out", $signed(result_out), exp_result.pop_front());
        end
        if (resv32) begin
            check("done_out_32", longint'(done32), 1);
            if (exp_result32.size() == 0) unexpected("result_out_32", $signed(result32));
            else check("result_out_32", $signed(result32), exp_result32.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic m, input int n, input logic both);
        mode_in  = m;
        count_in = 8'(n);
        start_in = 1'b1;
        start32  = both;
        tick();
        start_in = 1'b0;
        start32  = 1'b0;
    endtask

    task automatic op_raw(input int l, input int t, input logic l_v, input logic t_v);
        left_in = 16'(l);
        top_in  = 16'(t);
        lv      = l_v;
        tv      = t_v;
        tick();
    endtask

    task automatic op_os(input int l, input int t);
        exp_right.push_back(l);
        exp_bottom.push_back(t);
        op_raw(l, t, 1'b1, 1'b1);
    endtask

    task automatic op_ws(input int l, input int ps, input logic t_v, input int exp_b);
        exp_right.push_back(l);
        exp_bottom.push_back(exp_b);
        op_raw(l, ps, 1'b1, t_v);
    endtask

    task automatic idle(input int n);
        lv = 1'b0;
        tv = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("reset_right_out", longint'(right_out), 0);
        check("reset_result_out", longint'(result_out), 0);
        check("reset_valids", longint'({right_valid_out, bottom_valid_out, result_valid_out}), 0);
        check("reset_busy_done", longint'({busy_out, done_out}), 0);
        rst = 1'b1;
        tick();

        // OS, three paired operands: 6 - 20 + 7
        exp_result.push_back(-7);
        start_job(1'b0, 3, 1'b0);
        check("busy_in_job", longint'(busy_out), 1);
        op_os(2, 3);
        op_os(-4, 5);
        op_os(7, 1);
        idle(2);
        check("busy_after_job", longint'(busy_out), 0);

        // OS with left valid toggling; a start mid-job must be ignored
        exp_result.push_back(7);
        start_job(1'b0, 2, 1'b0);
        op_os(3, 3);
        start_in = 1'b1;
        mode_in  = 1'b1;
        count_in = 8'd0;
        op_raw(5, 9, 1'b0, 1'b1);
        start_in = 1'b0;
        mode_in  = 1'b0;
        op_raw(8, 8, 1'b1, 1'b0);
        op_os(1, -2);
        idle(2);

        // count 0 goes straight to DRAIN with a cleared accumulator
        exp_result.push_back(0);
        start_job(1'b0, 0, 1'b0);
        idle(2);

        // WS: weight 5 loaded only once top is valid; LOAD forwards nothing
        exp_result.push_back(0);
        start_job(1'b1, 2, 1'b0);
        op_raw(9, 7, 1'b1, 1'b0);
        op_raw(9, 5, 1'b1, 1'b1);
        op_ws(2, 10, 1'b1, 20);
        op_ws(-3, 99, 1'b0, -15);
        idle(2);

        // WS word saturation, both directions
        exp_result.push_back(0);
        start_job(1'b1, 2, 1'b0);
        op_raw(0, 32767, 1'b0, 1'b1);
        op_ws(2, 1, 1'b1, 32767);
        op_ws(-2, -5, 1'b1, -32768);
        idle(2);

        // OS 32767^2 x3: exact in 40 bits, clamped in 32 bits
        exp_result.push_back(64'd3221028867);
        exp_result32.push_back(64'd2147483647);
        start_job(1'b0, 3, 1'b1);
        op_os(32767, 32767);
        op_os(32767, 32767);
        op_os(32767, 32767);
        idle(2);

        // Smart-bus operands and bus outputs
        sel_l = 1'b1; sel_t = 1'b1; sel_r = 1'b1; sel_b = 1'b1;
        hbus_in = 16'h00AA;
        vbus_in = 16'h0055;
        exp_right.push_back(170);
        exp_bottom.push_back(85);
        exp_result.push_back(14450);
        start_job(1'b0, 1, 1'b0);
        op_raw(1, 1, 1'b1, 1'b1);
        @(negedge clk);
        check("hbus_out_driven", longint'(hbus_out), 170);
        check("vbus_out_driven", longint'(vbus_out), 85);
        lv = 1'b0; tv = 1'b0;
        sel_l = 1'b0; sel_t = 1'b0; sel_r = 1'b0; sel_b = 1'b0;
        hbus_in = 16'h1234;
        vbus_in = 16'h0F0F;
        #1;
        check("hbus_out_pass", longint'(hbus_out), 4660);
        check("vbus_out_pass", longint'(vbus_out), 3855);
        idle(2);

        // Reset mid-COMPUTE, then a fresh job
        start_job(1'b0, 4, 1'b0);
        op_os(1, 1);
        op_os(2, 2);
        lv = 1'b0; tv = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_right_out", longint'(right_out), 0);
        check("midrst_bottom_out", longint'(bottom_out), 0);
        check("midrst_result_out", longint'(result_out), 0);
        check("midrst_flags", longint'({right_valid_out, bottom_valid_out, busy_out, done_out}), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        exp_result.push_back(42);
        start_job(1'b0, 1, 1'b0);
        op_os(6, 7);
        idle(3);

        check("right_queue_drained", exp_right.size(), 0);
        check("bottom_queue_drained", exp_bottom.size(), 0);
        check("result_queue_drained", exp_result.size(), 0);
        check("result32_queue_drained", exp_result32.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
